// File: rtl/operand_arb_mux.sv
// N-channel registered selector with valid/ready on every channel and on the output.
// Selection is either direct (by sel) or round-robin among the valid channels.
module operand_arb_mux #(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int NSLOT = 1 << SELW;

  // Channels are padded out to every index sel can encode; slots >= NCH are
  // never valid, so an out-of-range sel simply finds nothing to grant.
  logic [NSLOT-1:0] valid_pad;
  logic [WIDTH-1:0] ch_data [NSLOT];

  generate
    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_pad
      if (gi < NCH) begin : g_real
        assign valid_pad[gi] = in_valid[gi];
        assign ch_data[gi]   = in_data[gi*WIDTH +: WIDTH];
      end else begin : g_empty
        assign valid_pad[gi] = 1'b0;
        assign ch_data[gi]   = '0;
      end
    end
  endgenerate

  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic [SELW-1:0]  out_ch_reg, out_ch_next;
  logic             out_valid_reg, out_valid_next;
  logic [SELW-1:0]  ptr_reg, ptr_next;

  logic            dir_hit;
  logic            rr_hit;
  logic [SELW-1:0] rr_idx;
  logic            grant_valid;
  logic [SELW-1:0] grant;
  logic            load_en;
  logic            accept;

  assign dir_hit = (int'(sel) < NCH) && valid_pad[sel];

  // Round-robin search starts just after the last round-robin grant and ends on it.
  always_comb begin
    logic [SELW:0]   cand_wide;
    logic [SELW-1:0] cand;
    rr_hit    = 1'b0;
    rr_idx    = '0;
    cand_wide = '0;
    cand      = '0;
    for (int k = 1; k <= NCH; k++) begin
      cand_wide = {1'b0, ptr_reg} + (SELW+1)'(k);
      if (cand_wide >= (SELW+1)'(NCH)) begin
        cand_wide = cand_wide - (SELW+1)'(NCH);
      end
      cand = cand_wide[SELW-1:0];
      if (!rr_hit && valid_pad[cand]) begin
        rr_hit = 1'b1;
        rr_idx = cand;
      end
    end
  end

  assign grant_valid = mode ? rr_hit : dir_hit;
  assign grant       = mode ? rr_idx : sel;
  assign load_en     = !out_valid_reg || out_ready;
  assign accept      = load_en && grant_valid && !rst;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ready
      assign in_ready[gi] = accept && (grant == SELW'(gi));
    end
  endgenerate

  always_comb begin
    out_data_next  = out_data_reg;
    out_ch_next    = out_ch_reg;
    out_valid_next = out_valid_reg;
    ptr_next       = ptr_reg;
    if (accept) begin
      out_data_next  = ch_data[grant];
      out_ch_next    = grant;
      out_valid_next = 1'b1;
      if (mode) begin
        ptr_next = grant;
      end
    end else if (out_valid_reg && out_ready) begin
      // Drained with nothing to replace it; data and channel keep their last values.
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
      out_valid_reg <= 1'b0;
      ptr_reg       <= SELW'(NCH - 1);
    end else begin
      out_data_reg  <= out_data_next;
      out_ch_reg    <= out_ch_next;
      out_valid_reg <= out_valid_next;
      ptr_reg       <= ptr_next;
    end
  end

  assign out_data  = out_data_reg;
  assign out_ch    = out_ch_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_operand_arb_mux.sv
// Directed bench for operand_arb_mux: a 4-channel instance driven from a vector
// table, plus a 3-channel instance for out-of-range sel and non-power-of-2 wrap.
module tb_operand_arb_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-channel instance
  logic        rst0, mode0, ordy0;
  logic [1:0]  sel0;
  logic [63:0] data0;
  logic [3:0]  valid0, rdy0;
  logic [15:0] od0;
  logic [1:0]  och0;
  logic        ov0;

  operand_arb_mux #(.WIDTH(16), .NCH(4), .SELW(2)) u0 (
    .clk(clk), .rst(rst0), .mode(mode0), .sel(sel0),
    .in_data(data0), .in_valid(valid0), .in_ready(rdy0),
    .out_data(od0), .out_ch(och0), .out_valid(ov0), .out_ready(ordy0)
  );

  // 3-channel instance
  logic        rst1, mode1, ordy1;
  logic [1:0]  sel1;
  logic [47:0] data1;
  logic [2:0]  valid1, rdy1;
  logic [15:0] od1;
  logic [1:0]  och1;
  logic        ov1;

  operand_arb_mux #(.WIDTH(16), .NCH(3), .SELW(2)) u1 (
    .clk(clk), .rst(rst1), .mode(mode1), .sel(sel1),
    .in_data(data1), .in_valid(valid1), .in_ready(rdy1),
    .out_data(od1), .out_ch(och1), .out_valid(ov1), .out_ready(ordy1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  valid;
    logic        ordy;
    logic [63:0] data;
    logic [3:0]  e_rdy;
    logic        e_ov;
    logic [15:0] e_od;
    logic [1:0]  e_och;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic m, input logic [1:0] s,
                              input logic [3:0] v, input logic o, input logic [63:0] d,
                              input logic [3:0] er, input logic eov,
                              input logic [15:0] eod, input logic [1:0] ech);
    vec_t t;
    t.rst = r; t.mode = m; t.sel = s; t.valid = v; t.ordy = o; t.data = d;
    t.e_rdy = er; t.e_ov = eov; t.e_od = eod; t.e_och = ech;
    return t;
  endfunction

  localparam logic [63:0] D  = 64'h1003_1002_1001_1000;
  localparam logic [63:0] DB = 64'h1003_BEEF_1001_1000;
  localparam int NV = 27;
  vec_t vecs [NV];

  logic [2:0]  rr_rdy [4];
  logic [15:0] rr_od  [4];
  logic [1:0]  rr_ch  [4];

  initial begin
    // rst mode sel valid ordy data | in_ready out_valid out_data out_ch (after edge)
    vecs[0]  = mk(1, 1, 0, 4'b1111, 1, D,  4'b0000, 0, 16'h0000, 0);
    vecs[1]  = mk(1, 1, 0, 4'b1111, 1, D,  4'b0000, 0, 16'h0000, 0);
    vecs[2]  = mk(0, 1, 0, 4'b1111, 1, D,  4'b0001, 1, 16'h1000, 0);
    vecs[3]  = mk(0, 1, 0, 4'b1111, 1, D,  4'b0010, 1, 16'h1001, 1);
    vecs[4]  = mk(0, 1, 0, 4'b1111, 1, D,  4'b0100, 1, 16'h1002, 2);
    vecs[5]  = mk(0, 1, 0, 4'b1111, 1, D,  4'b1000, 1, 16'h1003, 3);
    vecs[6]  = mk(0, 1, 0, 4'b1111, 1, D,  4'b0001, 1, 16'h1000, 0);
    vecs[7]  = mk(0, 1, 0, 4'b1111, 1, D,  4'b0010, 1, 16'h1001, 1);
    vecs[8]  = mk(0, 1, 0, 4'b1111, 1, D,  4'b0100, 1, 16'h1002, 2);
    vecs[9]  = mk(0, 1, 0, 4'b1111, 1, D,  4'b1000, 1, 16'h1003, 3);
    // direct select, then a non-valid selected channel drains the register
    vecs[10] = mk(0, 0, 2, 4'b1111, 1, DB, 4'b0100, 1, 16'hBEEF, 2);
    vecs[11] = mk(0, 0, 1, 4'b1101, 1, DB, 4'b0000, 0, 16'hBEEF, 2);
    vecs[12] = mk(0, 0, 1, 4'b1101, 1, DB, 4'b0000, 0, 16'hBEEF, 2);
    // ptr is still 3 after direct accepts: channel 0 first, then skip/wrap 3,0,3
    vecs[13] = mk(0, 1, 0, 4'b0001, 1, D,  4'b0001, 1, 16'h1000, 0);
    vecs[14] = mk(0, 1, 0, 4'b1001, 1, D,  4'b1000, 1, 16'h1003, 3);
    vecs[15] = mk(0, 1, 0, 4'b1001, 1, D,  4'b0001, 1, 16'h1000, 0);
    vecs[16] = mk(0, 1, 0, 4'b1001, 1, D,  4'b1000, 1, 16'h1003, 3);
    // single valid channel granted every cycle
    vecs[17] = mk(0, 1, 0, 4'b0100, 1, D,  4'b0100, 1, 16'h1002, 2);
    vecs[18] = mk(0, 1, 0, 4'b0100, 1, D,  4'b0100, 1, 16'h1002, 2);
    // backpressure for 3 cycles (mode flip in the middle must not disturb the held word)
    vecs[19] = mk(0, 1, 0, 4'b1111, 0, D,  4'b0000, 1, 16'h1002, 2);
    vecs[20] = mk(0, 0, 0, 4'b1111, 0, D,  4'b0000, 1, 16'h1002, 2);
    vecs[21] = mk(0, 1, 0, 4'b1111, 0, D,  4'b0000, 1, 16'h1002, 2);
    vecs[22] = mk(0, 1, 0, 4'b1111, 1, D,  4'b1000, 1, 16'h1003, 3);
    vecs[23] = mk(0, 1, 0, 4'b1111, 1, D,  4'b0001, 1, 16'h1000, 0);
    // reset while holding a stalled word
    vecs[24] = mk(0, 1, 0, 4'b1111, 0, D,  4'b0000, 1, 16'h1000, 0);
    vecs[25] = mk(1, 1, 0, 4'b1111, 0, D,  4'b0000, 0, 16'h0000, 0);
    vecs[26] = mk(0, 1, 0, 4'b0110, 1, D,  4'b0010, 1, 16'h1001, 1);

    rst0 = 1'b1; mode0 = 1'b0; sel0 = '0; valid0 = '0; ordy0 = 1'b0; data0 = '0;
    rst1 = 1'b1; mode1 = 1'b0; sel1 = '0; valid1 = '0; ordy1 = 1'b0;
    data1 = 48'hC002_C001_C000;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst0 = vecs[i].rst; mode0 = vecs[i].mode; sel0 = vecs[i].sel;
      valid0 = vecs[i].valid; ordy0 = vecs[i].ordy; data0 = vecs[i].data;
      #1;
      check($sformatf("v%0d in_ready", i), 32'(rdy0), 32'(vecs[i].e_rdy));
      @(posedge clk);
      #1;
      check($sformatf("v%0d out_valid", i), 32'(ov0), 32'(vecs[i].e_ov));
      check($sformatf("v%0d out_data", i), 32'(od0), 32'(vecs[i].e_od));
      check($sformatf("v%0d out_ch", i), 32'(och0), 32'(vecs[i].e_och));
      $display("vec %0d: in_ready=%b out_valid=%0b out_data=%h out_ch=%0d",
               i, rdy0, ov0, od0, och0);
    end

    // 3-channel instance: reset, then sel=3 must never grant
    @(negedge clk);
    rst1 = 1'b1; valid1 = 3'b111; ordy1 = 1'b1; mode1 = 1'b0; sel1 = 2'd3;
    #1;
    check("n3 rst in_ready", 32'(rdy1), 32'h0);
    @(posedge clk);
    #1;
    check("n3 rst out_valid", 32'(ov1), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst1 = 1'b0; mode1 = 1'b0; sel1 = 2'd3;
      #1;
      check($sformatf("n3 sel3 in_ready %0d", i), 32'(rdy1), 32'h0);
      @(posedge clk);
      #1;
      check($sformatf("n3 sel3 out_valid %0d", i), 32'(ov1), 32'h0);
      $display("n3 sel3 cycle %0d: in_ready=%b out_valid=%0b", i, rdy1, ov1);
    end

    // direct accept of channel 1 must leave ptr at 2 for round-robin
    @(negedge clk);
    sel1 = 2'd1;
    #1;
    check("n3 sel1 in_ready", 32'(rdy1), 32'h2);
    @(posedge clk);
    #1;
    check("n3 sel1 out_data", 32'(od1), 32'hC001);
    check("n3 sel1 out_ch", 32'(och1), 32'h1);
    $display("n3 sel1: in_ready=%b out_data=%h out_ch=%0d", rdy1, od1, och1);

    rr_rdy[0] = 3'b001; rr_od[0] = 16'hC000; rr_ch[0] = 2'd0;
    rr_rdy[1] = 3'b010; rr_od[1] = 16'hC001; rr_ch[1] = 2'd1;
    rr_rdy[2] = 3'b100; rr_od[2] = 16'hC002; rr_ch[2] = 2'd2;
    rr_rdy[3] = 3'b001; rr_od[3] = 16'hC000; rr_ch[3] = 2'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mode1 = 1'b1;
      #1;
      check($sformatf("n3 rr%0d in_ready", i), 32'(rdy1), 32'(rr_rdy[i]));
      @(posedge clk);
      #1;
      check($sformatf("n3 rr%0d out_data", i), 32'(od1), 32'(rr_od[i]));
      check($sformatf("n3 rr%0d out_ch", i), 32'(och1), 32'(rr_ch[i]));
      $display("n3 rr %0d: in_ready=%b out_data=%h out_ch=%0d", i, rdy1, od1, och1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
